lsu: RTL and testbench

Load/store unit and EX/WB pipeline register of the riscx core. It sits directly after the execute stage and consumes the ALU result, which is either a computed effective address or a finished arithmetic result. For loads and stores it runs a single outstanding request on a req/gnt/rvalid data bus, aligns and extends load data, and generates byte enables for stores. Every instruction it accepts is presented to writeback as exactly one registered `wb_valid_o` pulse.

---
 rtl/lsu.sv | 230 +++++++++++++++++++++++
 tb/tb_lsu.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/lsu.sv
// Load/store unit and EX/WB pipeline register. One bus request at a time.
// Every accepted instruction retires as exactly one registered wb_valid_o pulse.
module lsu #(
  parameter int XLEN          = 32,
  parameter int PC_WIDTH      = 32,
  parameter int REG_IDX_WIDTH = 5
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     ex_valid_i,
  output logic                     ex_ready_o,
  input  logic [PC_WIDTH-1:0]      pc_i,
  input  logic [31:0]              instr_i,
  input  logic [XLEN-1:0]          alu_res_i,
  input  logic [XLEN-1:0]          rs2_rdata_i,
  input  logic [REG_IDX_WIDTH-1:0] rd_idx_i,
  input  logic                     rd_en_i,
  output logic                     bus_req_o,
  output logic                     bus_we_o,
  output logic [XLEN-1:0]          bus_addr_o,
  output logic [XLEN-1:0]          bus_wdata_o,
  output logic [3:0]               bus_be_o,
  input  logic                     bus_gnt_i,
  input  logic                     bus_rvalid_i,
  input  logic [XLEN-1:0]          bus_rdata_i,
  input  logic                     bus_err_i,
  output logic                     wb_valid_o,
  output logic [PC_WIDTH-1:0]      wb_pc_o,
  output logic [REG_IDX_WIDTH-1:0] wb_rd_idx_o,
  output logic                     wb_rd_en_o,
  output logic [XLEN-1:0]          wb_data_o,
  output logic                     lsu_misalign_o,
  output logic                     lsu_bus_err_o
);

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT} state_e;

  state_e                   state_q, state_d;
  logic                     is_store_q, is_store_d;
  logic [2:0]               funct3_q, funct3_d;
  logic [1:0]               addr_lo_q, addr_lo_d;
  logic [PC_WIDTH-1:0]      pc_q, pc_d;
  logic [REG_IDX_WIDTH-1:0] rd_idx_q, rd_idx_d;
  logic                     rd_en_q, rd_en_d;
  logic                     bus_req_q, bus_req_d;
  logic                     bus_we_q, bus_we_d;
  logic [XLEN-1:0]          bus_addr_q, bus_addr_d;
  logic [XLEN-1:0]          bus_wdata_q, bus_wdata_d;
  logic [3:0]               bus_be_q, bus_be_d;
  logic                     wb_valid_q, wb_valid_d;
  logic [PC_WIDTH-1:0]      wb_pc_q, wb_pc_d;
  logic [REG_IDX_WIDTH-1:0] wb_rd_idx_q, wb_rd_idx_d;
  logic                     wb_rd_en_q, wb_rd_en_d;
  logic [XLEN-1:0]          wb_data_q, wb_data_d;
  logic                     misalign_q, misalign_d;
  logic                     bus_err_q, bus_err_d;

  logic [6:0]      opcode;
  logic [2:0]      funct3;
  logic            is_load, is_store, is_mem, misalign;
  logic [3:0]      st_be;
  logic [XLEN-1:0] st_wdata;
  logic [XLEN-1:0] ld_shift;
  logic [XLEN-1:0] ld_data;
  logic            unused_instr;

  assign opcode       = instr_i[6:0];
  assign funct3       = instr_i[14:12];
  assign unused_instr = ^{instr_i[31:15], instr_i[11:7]};
  assign is_load      = (opcode == 7'b0000011);
  assign is_store     = (opcode == 7'b0100011);
  assign is_mem       = is_load | is_store;
  // funct3[1:0] encodes size: 00 byte, 01 half, 1x word
  assign misalign     = is_mem & (((funct3[1:0] == 2'b01) & alu_res_i[0]) |
                                  (funct3[1] & (alu_res_i[1:0] != 2'b00)));

  always_comb begin
    st_be    = 4'b1111;
    st_wdata = rs2_rdata_i;
    if (funct3[1:0] == 2'b00) begin
      st_be    = 4'b0001 << alu_res_i[1:0];
      st_wdata = {4{rs2_rdata_i[7:0]}};
    end else if (funct3[1:0] == 2'b01) begin
      st_be    = 4'b0011 << {alu_res_i[1], 1'b0};
      st_wdata = {2{rs2_rdata_i[15:0]}};
    end
  end

  assign ld_shift = bus_rdata_i >> {addr_lo_q, 3'b000};

  always_comb begin
    case (funct3_q)
      3'b000:  ld_data = {{(XLEN-8){ld_shift[7]}}, ld_shift[7:0]};
      3'b100:  ld_data = {{(XLEN-8){1'b0}}, ld_shift[7:0]};
      3'b001:  ld_data = {{(XLEN-16){ld_shift[15]}}, ld_shift[15:0]};
      3'b101:  ld_data = {{(XLEN-16){1'b0}}, ld_shift[15:0]};
      default: ld_data = bus_rdata_i;
    endcase
  end

  always_comb begin
    state_d     = state_q;
    is_store_d  = is_store_q;
    funct3_d    = funct3_q;
    addr_lo_d   = addr_lo_q;
    pc_d        = pc_q;
    rd_idx_d    = rd_idx_q;
    rd_en_d     = rd_en_q;
    bus_req_d   = bus_req_q;
    bus_we_d    = bus_we_q;
    bus_addr_d  = bus_addr_q;
    bus_wdata_d = bus_wdata_q;
    bus_be_d    = bus_be_q;
    wb_valid_d  = 1'b0;
    wb_pc_d     = wb_pc_q;
    wb_rd_idx_d = wb_rd_idx_q;
    wb_rd_en_d  = 1'b0;
    wb_data_d   = wb_data_q;
    misalign_d  = 1'b0;
    bus_err_d   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (ex_valid_i) begin
          if (is_mem && !misalign) begin
            state_d     = S_REQ;
            is_store_d  = is_store;
            funct3_d    = funct3;
            addr_lo_d   = alu_res_i[1:0];
            pc_d        = pc_i;
            rd_idx_d    = rd_idx_i;
            rd_en_d     = rd_en_i;
            bus_req_d   = 1'b1;
            bus_we_d    = is_store;
            bus_addr_d  = {alu_res_i[XLEN-1:2], 2'b00};
            bus_be_d    = is_store ? st_be : 4'b0000;
            bus_wdata_d = is_store ? st_wdata : '0;
          end else begin
            wb_valid_d  = 1'b1;
            wb_pc_d     = pc_i;
            wb_rd_idx_d = rd_idx_i;
            wb_rd_en_d  = rd_en_i & ~is_mem;
            wb_data_d   = alu_res_i;
            misalign_d  = is_mem;
          end
        end
      end
      S_REQ: begin
        if (bus_gnt_i) begin
          state_d     = S_WAIT;
          bus_req_d   = 1'b0;
          bus_we_d    = 1'b0;
          bus_addr_d  = '0;
          bus_wdata_d = '0;
          bus_be_d    = 4'b0000;
        end
      end
      S_WAIT: begin
        if (bus_rvalid_i) begin
          state_d     = S_IDLE;
          wb_valid_d  = 1'b1;
          wb_pc_d     = pc_q;
          wb_rd_idx_d = rd_idx_q;
          wb_rd_en_d  = rd_en_q & ~is_store_q & ~bus_err_i;
          wb_data_d   = (is_store_q || bus_err_i) ? '0 : ld_data;
          bus_err_d   = bus_err_i;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      is_store_q  <= 1'b0;
      funct3_q    <= 3'b000;
      addr_lo_q   <= 2'b00;
      pc_q        <= '0;
      rd_idx_q    <= '0;
      rd_en_q     <= 1'b0;
      bus_req_q   <= 1'b0;
      bus_we_q    <= 1'b0;
      bus_addr_q  <= '0;
      bus_wdata_q <= '0;
      bus_be_q    <= 4'b0000;
      wb_valid_q  <= 1'b0;
      wb_pc_q     <= '0;
      wb_rd_idx_q <= '0;
      wb_rd_en_q  <= 1'b0;
      wb_data_q   <= '0;
      misalign_q  <= 1'b0;
      bus_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      is_store_q  <= is_store_d;
      funct3_q    <= funct3_d;
      addr_lo_q   <= addr_lo_d;
      pc_q        <= pc_d;
      rd_idx_q    <= rd_idx_d;
      rd_en_q     <= rd_en_d;
      bus_req_q   <= bus_req_d;
      bus_we_q    <= bus_we_d;
      bus_addr_q  <= bus_addr_d;
      bus_wdata_q <= bus_wdata_d;
      bus_be_q    <= bus_be_d;
      wb_valid_q  <= wb_valid_d;
      wb_pc_q     <= wb_pc_d;
      wb_rd_idx_q <= wb_rd_idx_d;
      wb_rd_en_q  <= wb_rd_en_d;
      wb_data_q   <= wb_data_d;
      misalign_q  <= misalign_d;
      bus_err_q   <= bus_err_d;
    end
  end

  assign ex_ready_o     = (state_q == S_IDLE);
  assign bus_req_o      = bus_req_q;
  assign bus_we_o       = bus_we_q;
  assign bus_addr_o     = bus_addr_q;
  assign bus_wdata_o    = bus_wdata_q;
  assign bus_be_o       = bus_be_q;
  assign wb_valid_o     = wb_valid_q;
  assign wb_pc_o        = wb_pc_q;
  assign wb_rd_idx_o    = wb_rd_idx_q;
  assign wb_rd_en_o     = wb_rd_en_q;
  assign wb_data_o      = wb_data_q;
  assign lsu_misalign_o = misalign_q;
  assign lsu_bus_err_o  = bus_err_q;

endmodule

// File: tb/tb_lsu.sv
// Directed self-checking bench for lsu: one task per scenario with inline checks
// against hand-computed values.
module tb_lsu;

  localparam logic [31:0] I_ADD = 32'h0000_0033;
  localparam logic [31:0] I_LB  = 32'h0000_0003;
  localparam logic [31:0] I_LW  = 32'h0000_2003;
  localparam logic [31:0] I_LHU = 32'h0000_5003;
  localparam logic [31:0] I_SB  = 32'h0000_0023;
  localparam logic [31:0] I_SH  = 32'h0000_1023;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        ex_valid_i = 1'b0;
  logic        ex_ready_o;
  logic [31:0] pc_i = '0;
  logic [31:0] instr_i = '0;
  logic [31:0] alu_res_i = '0;
  logic [31:0] rs2_rdata_i = '0;
  logic [4:0]  rd_idx_i = '0;
  logic        rd_en_i = 1'b0;
  logic        bus_req_o;
  logic        bus_we_o;
  logic [31:0] bus_addr_o;
  logic [31:0] bus_wdata_o;
  logic [3:0]  bus_be_o;
  logic        bus_gnt_i = 1'b0;
  logic        bus_rvalid_i = 1'b0;
  logic [31:0] bus_rdata_i = '0;
  logic        bus_err_i = 1'b0;
  logic        wb_valid_o;
  logic [31:0] wb_pc_o;
  logic [4:0]  wb_rd_idx_o;
  logic        wb_rd_en_o;
  logic [31:0] wb_data_o;
  logic        lsu_misalign_o;
  logic        lsu_bus_err_o;

  int tests_run = 0;
  int tests_failed = 0;

  always #5 clk = ~clk;

  lsu dut (
    .clk(clk), .rst_n(rst_n),
    .ex_valid_i(ex_valid_i), .ex_ready_o(ex_ready_o),
    .pc_i(pc_i), .instr_i(instr_i), .alu_res_i(alu_res_i),
    .rs2_rdata_i(rs2_rdata_i), .rd_idx_i(rd_idx_i), .rd_en_i(rd_en_i),
    .bus_req_o(bus_req_o), .bus_we_o(bus_we_o), .bus_addr_o(bus_addr_o),
    .bus_wdata_o(bus_wdata_o), .bus_be_o(bus_be_o), .bus_gnt_i(bus_gnt_i),
    .bus_rvalid_i(bus_rvalid_i), .bus_rdata_i(bus_rdata_i), .bus_err_i(bus_err_i),
    .wb_valid_o(wb_valid_o), .wb_pc_o(wb_pc_o), .wb_rd_idx_o(wb_rd_idx_o),
    .wb_rd_en_o(wb_rd_en_o), .wb_data_o(wb_data_o),
    .lsu_misalign_o(lsu_misalign_o), .lsu_bus_err_o(lsu_bus_err_o)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [31:0] instr, input logic [31:0] alu, input logic [31:0] rs2,
                       input logic [4:0] rd, input logic rd_en, input logic [31:0] pc);
    ex_valid_i  = 1'b1;
    instr_i     = instr;
    alu_res_i   = alu;
    rs2_rdata_i = rs2;
    rd_idx_i    = rd;
    rd_en_i     = rd_en;
    pc_i        = pc;
  endtask

  task automatic test_reset();
    #1;
    tests_run++; if (ex_ready_o !== 1'b1) begin tests_failed++; $display("[TB] FAIL reset_ready: got %b want 1", ex_ready_o); end
    tests_run++; if ({bus_req_o, bus_we_o, bus_addr_o, bus_wdata_o, bus_be_o} !== '0) begin tests_failed++; $display("[TB] FAIL reset_bus: req=%b addr=%h be=%b want all 0", bus_req_o, bus_addr_o, bus_be_o); end
    tests_run++; if ({wb_valid_o, wb_pc_o, wb_rd_idx_o, wb_rd_en_o, wb_data_o, lsu_misalign_o, lsu_bus_err_o} !== '0) begin tests_failed++; $display("[TB] FAIL reset_wb: valid=%b data=%h want all 0", wb_valid_o, wb_data_o); end
    step();
    step();
    rst_n = 1'b1;
    step();
  endtask

  task automatic test_add();
    drive(I_ADD, 32'h1234, 32'h0, 5'd5, 1'b1, 32'h100);
    step();
    ex_valid_i = 1'b0;
    tests_run++; if (wb_valid_o !== 1'b1) begin tests_failed++; $display("[TB] FAIL add_valid: got %b want 1", wb_valid_o); end
    tests_run++; if (wb_data_o !== 32'h1234) begin tests_failed++; $display("[TB] FAIL add_data: got %h want 00001234", wb_data_o); end
    tests_run++; if (wb_rd_idx_o !== 5'd5 || wb_rd_en_o !== 1'b1) begin tests_failed++; $display("[TB] FAIL add_rd: got idx=%0d en=%b want 5/1", wb_rd_idx_o, wb_rd_en_o); end
    tests_run++; if (wb_pc_o !== 32'h100) begin tests_failed++; $display("[TB] FAIL add_pc: got %h want 00000100", wb_pc_o); end
    step();
    tests_run++; if (wb_valid_o !== 1'b0 || wb_rd_en_o !== 1'b0) begin tests_failed++; $display("[TB] FAIL add_pulse: got valid=%b en=%b want 0/0", wb_valid_o, wb_rd_en_o); end
  endtask

  task automatic test_lb_sign();
    drive(I_LB, 32'h1003, 32'h0, 5'd7, 1'b1, 32'h104);
    step();
    ex_valid_i = 1'b0;
    tests_run++; if (bus_req_o !== 1'b1 || bus_we_o !== 1'b0) begin tests_failed++; $display("[TB] FAIL lb_req: got req=%b we=%b want 1/0", bus_req_o, bus_we_o); end
    tests_run++; if (bus_addr_o !== 32'h1000) begin tests_failed++; $display("[TB] FAIL lb_addr: got %h want 00001000", bus_addr_o); end
    tests_run++; if (bus_be_o !== 4'b0000) begin tests_failed++; $display("[TB] FAIL lb_be: got %b want 0000", bus_be_o); end
    tests_run++; if (ex_ready_o !== 1'b0) begin tests_failed++; $display("[TB] FAIL lb_ready_req: got %b want 0", ex_ready_o); end
    bus_gnt_i = 1'b1;
    step();
    bus_gnt_i = 1'b0;
    tests_run++; if (bus_req_o !== 1'b0 || ex_ready_o !== 1'b0 || wb_valid_o !== 1'b0) begin tests_failed++; $display("[TB] FAIL lb_wait: got req=%b ready=%b valid=%b want 0/0/0", bus_req_o, ex_ready_o, wb_valid_o); end
    bus_rvalid_i = 1'b1;
    bus_rdata_i  = 32'h80FF_0000;
    step();
    bus_rvalid_i = 1'b0;
    tests_run++; if (wb_valid_o !== 1'b1 || wb_rd_en_o !== 1'b1 || wb_rd_idx_o !== 5'd7) begin tests_failed++; $display("[TB] FAIL lb_wb: got valid=%b en=%b idx=%0d want 1/1/7", wb_valid_o, wb_rd_en_o, wb_rd_idx_o); end
    tests_run++; if (wb_data_o !== 32'hFFFF_FF80) begin tests_failed++; $display("[TB] FAIL lb_data: got %h want ffffff80", wb_data_o); end
    tests_run++; if (ex_ready_o !== 1'b1) begin tests_failed++; $display("[TB] FAIL lb_ready_done: got %b want 1", ex_ready_o); end
    step();
  endtask

  task automatic test_sh_stall();
    drive(I_SH, 32'h2002, 32'h1234_ABCD, 5'd3, 1'b1, 32'h108);
    step();
    ex_valid_i = 1'b0;
    for (int c = 0; c < 3; c++) begin
      tests_run++; if (bus_req_o !== 1'b1 || bus_we_o !== 1'b1 || bus_addr_o !== 32'h2000) begin tests_failed++; $display("[TB] FAIL sh_req%0d: got req=%b we=%b addr=%h want 1/1/00002000", c, bus_req_o, bus_we_o, bus_addr_o); end
      tests_run++; if (bus_be_o !== 4'b1100 || bus_wdata_o !== 32'hABCD_ABCD) begin tests_failed++; $display("[TB] FAIL sh_data%0d: got be=%b wdata=%h want 1100/abcdabcd", c, bus_be_o, bus_wdata_o); end
      tests_run++; if (ex_ready_o !== 1'b0) begin tests_failed++; $display("[TB] FAIL sh_ready%0d: got %b want 0", c, ex_ready_o); end
      bus_gnt_i = (c == 2);
      step();
    end
    bus_gnt_i = 1'b0;
    tests_run++; if (bus_req_o !== 1'b0 || ex_ready_o !== 1'b0) begin tests_failed++; $display("[TB] FAIL sh_wait: got req=%b ready=%b want 0/0", bus_req_o, ex_ready_o); end
    bus_rvalid_i = 1'b1;
    step();
    bus_rvalid_i = 1'b0;
    tests_run++; if (wb_valid_o !== 1'b1 || wb_rd_en_o !== 1'b0 || wb_pc_o !== 32'h108) begin tests_failed++; $display("[TB] FAIL sh_wb: got valid=%b en=%b pc=%h want 1/0/00000108", wb_valid_o, wb_rd_en_o, wb_pc_o); end
    step();
  endtask

  task automatic test_misalign();
    drive(I_LW, 32'h3001, 32'h0, 5'd4, 1'b1, 32'h10C);
    step();
    ex_valid_i = 1'b0;
    tests_run++; if (bus_req_o !== 1'b0 || ex_ready_o !== 1'b1) begin tests_failed++; $display("[TB] FAIL mis_noreq: got req=%b ready=%b want 0/1", bus_req_o, ex_ready_o); end
    tests_run++; if (wb_valid_o !== 1'b1 || lsu_misalign_o !== 1'b1 || wb_rd_en_o !== 1'b0) begin tests_failed++; $display("[TB] FAIL mis_wb: got valid=%b mis=%b en=%b want 1/1/0", wb_valid_o, lsu_misalign_o, wb_rd_en_o); end
    step();
    tests_run++; if (wb_valid_o !== 1'b0 || lsu_misalign_o !== 1'b0 || bus_req_o !== 1'b0) begin tests_failed++; $display("[TB] FAIL mis_pulse: got valid=%b mis=%b req=%b want 0/0/0", wb_valid_o, lsu_misalign_o, bus_req_o); end
  endtask

  task automatic test_back_to_back();
    drive(I_ADD, 32'h11, 32'h0, 5'd1, 1'b1, 32'h200);
    step();
    tests_run++; if (wb_valid_o !== 1'b1 || wb_data_o !== 32'h11 || lsu_misalign_o !== 1'b0) begin tests_failed++; $display("[TB] FAIL b2b_add: got valid=%b data=%h mis=%b want 1/00000011/0", wb_valid_o, wb_data_o, lsu_misalign_o); end
    drive(I_SH, 32'h3003, 32'h55, 5'd0, 1'b0, 32'h204);
    step();
    tests_run++; if (wb_valid_o !== 1'b1 || lsu_misalign_o !== 1'b1 || wb_pc_o !== 32'h204) begin tests_failed++; $display("[TB] FAIL b2b_mis: got valid=%b mis=%b pc=%h want 1/1/00000204", wb_valid_o, lsu_misalign_o, wb_pc_o); end
    drive(I_LHU, 32'h4002, 32'h0, 5'd9, 1'b1, 32'h208);
    step();
    ex_valid_i = 1'b0;
    tests_run++; if (wb_valid_o !== 1'b0 || bus_req_o !== 1'b1 || bus_addr_o !== 32'h4000) begin tests_failed++; $display("[TB] FAIL b2b_lhu_req: got valid=%b req=%b addr=%h want 0/1/00004000", wb_valid_o, bus_req_o, bus_addr_o); end
    bus_gnt_i = 1'b1;
    step();
    bus_gnt_i    = 1'b0;
    bus_rvalid_i = 1'b1;
    bus_rdata_i  = 32'h8765_4321;
    step();
    bus_rvalid_i = 1'b0;
    tests_run++; if (wb_valid_o !== 1'b1 || wb_data_o !== 32'h0000_8765 || wb_rd_idx_o !== 5'd9) begin tests_failed++; $display("[TB] FAIL b2b_lhu_data: got valid=%b data=%h idx=%0d want 1/00008765/9", wb_valid_o, wb_data_o, wb_rd_idx_o); end
    drive(I_SB, 32'h4001, 32'h0000_015A, 5'd2, 1'b1, 32'h20C);
    step();
    ex_valid_i = 1'b0;
    tests_run++; if (bus_req_o !== 1'b1 || bus_be_o !== 4'b0010 || bus_wdata_o !== 32'h5A5A_5A5A || bus_addr_o !== 32'h4000) begin tests_failed++; $display("[TB] FAIL b2b_sb: got req=%b be=%b wdata=%h addr=%h want 1/0010/5a5a5a5a/00004000", bus_req_o, bus_be_o, bus_wdata_o, bus_addr_o); end
    bus_gnt_i = 1'b1;
    step();
    bus_gnt_i    = 1'b0;
    bus_rvalid_i = 1'b1;
    step();
    bus_rvalid_i = 1'b0;
    tests_run++; if (wb_valid_o !== 1'b1 || wb_rd_en_o !== 1'b0) begin tests_failed++; $display("[TB] FAIL b2b_sb_wb: got valid=%b en=%b want 1/0", wb_valid_o, wb_rd_en_o); end
    step();
  endtask

  task automatic test_bus_err();
    drive(I_LW, 32'h5000, 32'h0, 5'd6, 1'b1, 32'h300);
    step();
    ex_valid_i = 1'b0;
    bus_gnt_i  = 1'b1;
    step();
    bus_gnt_i    = 1'b0;
    bus_rvalid_i = 1'b1;
    bus_err_i    = 1'b1;
    bus_rdata_i  = 32'hDEAD_BEEF;
    step();
    bus_rvalid_i = 1'b0;
    bus_err_i    = 1'b0;
    tests_run++; if (wb_valid_o !== 1'b1 || lsu_bus_err_o !== 1'b1 || wb_rd_en_o !== 1'b0) begin tests_failed++; $display("[TB] FAIL err_flags: got valid=%b err=%b en=%b want 1/1/0", wb_valid_o, lsu_bus_err_o, wb_rd_en_o); end
    tests_run++; if (wb_data_o !== 32'h0) begin tests_failed++; $display("[TB] FAIL err_data: got %h want 00000000", wb_data_o); end
    step();
    tests_run++; if (lsu_bus_err_o !== 1'b0 || wb_valid_o !== 1'b0) begin tests_failed++; $display("[TB] FAIL err_pulse: got err=%b valid=%b want 0/0", lsu_bus_err_o, wb_valid_o); end
  endtask

  task automatic test_reset_mid();
    drive(I_LW, 32'h6000, 32'h0, 5'd8, 1'b1, 32'h400);
    step();
    ex_valid_i = 1'b0;
    rst_n = 1'b0;
    #1;
    tests_run++; if (bus_req_o !== 1'b0 || ex_ready_o !== 1'b1) begin tests_failed++; $display("[TB] FAIL rst_req_async: got req=%b ready=%b want 0/1", bus_req_o, ex_ready_o); end
    step();
    rst_n = 1'b1;
    drive(I_LW, 32'h6004, 32'h0, 5'd8, 1'b1, 32'h404);
    step();
    ex_valid_i = 1'b0;
    bus_gnt_i  = 1'b1;
    step();
    bus_gnt_i = 1'b0;
    tests_run++; if (ex_ready_o !== 1'b0 || bus_req_o !== 1'b0) begin tests_failed++; $display("[TB] FAIL rst_in_wait: got ready=%b req=%b want 0/0", ex_ready_o, bus_req_o); end
    rst_n = 1'b0;
    #1;
    tests_run++; if (bus_req_o !== 1'b0 || wb_valid_o !== 1'b0 || ex_ready_o !== 1'b1) begin tests_failed++; $display("[TB] FAIL rst_wait_async: got req=%b valid=%b ready=%b want 0/0/1", bus_req_o, wb_valid_o, ex_ready_o); end
    step();
    rst_n        = 1'b1;
    bus_rvalid_i = 1'b1;
    bus_rdata_i  = 32'h1111_2222;
    step();
    bus_rvalid_i = 1'b0;
    tests_run++; if (wb_valid_o !== 1'b0 || ex_ready_o !== 1'b1 || bus_req_o !== 1'b0) begin tests_failed++; $display("[TB] FAIL rst_late_rvalid: got valid=%b ready=%b req=%b want 0/1/0", wb_valid_o, ex_ready_o, bus_req_o); end
  endtask

  initial begin
    test_reset();
    test_add();
    test_lb_sign();
    test_sh_stall();
    test_misalign();
    test_back_to_back();
    test_bus_err();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
